// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_W = 8;

  // Bit counter is wide enough to hold W itself, so it never wraps on the last step.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/fs_dataflow.sv
// Combinational full subtractor cell: d = x - y - bin, bo = borrow out.
module fs_dataflow (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bin;
  assign bo = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, LSB first, one bit per clock.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = cnt_width(W);

  state_t        state, state_nxt;
  logic [W-1:0]  a_sr, b_sr, diff_sr, diff_nxt;
  logic [CW-1:0] cnt;
  logic          borrow;
  logic          d, bo;
  logic          last;

  assign last = (cnt == CW'(W - 1));
  assign diff = diff_sr;

  fs_dataflow u_fs (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .bin(borrow),
    .d  (d),
    .bo (bo)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: start only matters in IDLE; DONE lasts exactly one cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from the state register only
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      DONE:    begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  // New result bit enters at the MSB; after W steps bit 0 holds the LSB
  always_comb begin
    diff_nxt        = diff_sr >> 1;
    diff_nxt[W-1]   = d;
  end

  // Datapath: capture on accepted start, one bit-step per RUN cycle.
  // bout is registered on the last step so it is valid together with done.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr    <= '0;
      b_sr    <= '0;
      diff_sr <= '0;
      borrow  <= 1'b0;
      cnt     <= '0;
      bout    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sr    <= a;
          b_sr    <= b;
          diff_sr <= '0;
          borrow  <= 1'b0;
          cnt     <= '0;
          bout    <= 1'b0;
        end
        RUN: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          diff_sr <= diff_nxt;
          borrow  <= bo;
          cnt     <= cnt + CW'(1);
          if (last) bout <= bo;
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb, b_msb;

  // Signed overflow: operand signs differ and result sign differs from minuend.
  // d on the last step is the result MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else if (state == IDLE && start) begin
      a_msb <= a[W-1];
      b_msb <= b[W-1];
      ovf   <= 1'b0;
    end else if (state == RUN && last) begin
      ovf   <= (a_msb ^ b_msb) & (a_msb ^ d);
    end
  end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (W=8 main instance plus a W=1 instance).
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] a, b;
  logic         busy, done, bout;
  logic [W-1:0] diff;
  logic         start1;
  logic [0:0]   a1, b1, diff1;
  logic         busy1, done1, bout1;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf, ovf1;
`endif

  serial_subtractor #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .bout(bout)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  serial_subtractor #(.W(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf1)
`endif
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    int           done_edge;
  } exp_t;

  exp_t sbq[$];

  // Reference: plain integer arithmetic on the operands
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input int acc);
    exp_t e;
    int ia = int'(x), ib = int'(y);
    int sa = int'($signed(x)), sb = int'($signed(y));
    int sd = sa - sb;
    e.diff      = W'(ia - ib);
    e.bout      = (ia < ib);
    e.ovf       = (sd > 127) || (sd < -128);
    e.done_edge = acc + W;
    return e;
  endfunction

  // Monitor: pop and compare whenever the DUT presents done
  exp_t mon_e;
  bit   prev_done = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        chk("done_single_cycle", 32'(prev_done), 32'd0);
        if (sbq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done actual=diff 0x%0h required=no result pending", diff);
        end else begin
          mon_e = sbq.pop_front();
          chk("done_edge", 32'(edge_n), 32'(mon_e.done_edge));
          chk("diff", 32'(diff), 32'(mon_e.diff));
          chk("bout", 32'(bout), 32'(mon_e.bout));
          chk("busy_at_done", 32'(busy), 32'd1);
`ifdef SERIAL_SUB_OVF_EN
          chk("ovf", 32'(ovf), 32'(mon_e.ovf));
`endif
        end
      end else if (sbq.size() > 0 && edge_n > sbq[0].done_edge) begin
        checks++; failures++;
        $display("FAIL missing_done actual=no done required=done at edge %0d", sbq[0].done_edge);
        void'(sbq.pop_front());
      end
      prev_done = done;
    end
  end

  int free_edge = 0;

  // Wait until the model says the DUT is idle, then issue one accepted start
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
    while (edge_n + 1 < free_edge) @(negedge clk);
    start = 1'b1; a = x; b = y;
    sbq.push_back(model(x, y, edge_n + 1));
    free_edge = edge_n + 1 + W + 2;
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return 8'h00;
      1:       return 8'hFF;
      2:       return 8'h80;
      3:       return 8'h7F;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ops;
    logic x1, y1;
    int e1;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    start1 = 1'b0; a1 = '0; b1 = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif
    rst = 1'b0;
    free_edge = edge_n + 1;

    // Directed operands
    issue(8'h5A, 8'h3C);
    issue(8'h00, 8'h01);
    issue(8'h80, 8'h01);
    issue(8'hFF, 8'hFF);

    // Start while busy must be ignored
    start = 1'b1; a = 8'h01; b = 8'h00;
    repeat (3) @(negedge clk);
    start = 1'b0;
    while (edge_n < free_edge + 1) @(negedge clk);
    chk("ignored_busy", 32'(busy), 32'd0);
    chk("ignored_diff_held", 32'(diff), 32'h00);
    chk("ignored_bout_held", 32'(bout), 32'd0);

    // Reset in RUN cycle 4 discards the operation
    while (edge_n + 1 < free_edge) @(negedge clk);
    start = 1'b1; a = 8'hA5; b = 8'h17;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_diff", 32'(diff), 32'd0);
    chk("midrst_bout", 32'(bout), 32'd0);
    rst = 1'b0;
    sbq.delete();
    free_edge = edge_n + 1;
    issue(8'h33, 8'h44);

    // Start held high continuously; junk operands while busy must not be captured
    while (edge_n + 1 < free_edge) @(negedge clk);
    ops = 0;
    start = 1'b1;
    while (ops < 1000) begin
      a = pick(); b = pick();
      if (edge_n + 1 >= free_edge) begin
        sbq.push_back(model(a, b, edge_n + 1));
        free_edge = edge_n + 1 + W + 2;
        ops++;
      end
      @(negedge clk);
    end
    start = 1'b0;
    repeat (W + 4) @(negedge clk);
    chk("queue_drained", 32'(sbq.size()), 32'd0);

    // W=1 instance: every operand pair
    for (int i = 0; i < 4; i++) begin
      x1 = i[1]; y1 = i[0];
      start1 = 1'b1; a1 = x1; b1 = y1;
      @(negedge clk);
      start1 = 1'b0;
      chk("w1_done_early", 32'(done1), 32'd0);
      @(negedge clk);
      chk("w1_done", 32'(done1), 32'd1);
      e1 = int'(x1) - int'(y1);
      chk("w1_diff", 32'(diff1), 32'(e1 & 1));
      chk("w1_bout", 32'(bout1), 32'(e1 < 0));
`ifdef SERIAL_SUB_OVF_EN
      // Signed 1-bit values are 0 and -1; only 0 - (-1) = +1 overflows
      chk("w1_ovf", 32'(ovf1), 32'(!x1 && y1));
`endif
      @(negedge clk);
      chk("w1_idle", 32'(busy1), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
